// File: rtl/pmp_trap_unit.sv
// PMP access-fault trap unit: captures fault cause/PC/address, raises a
// level trap request, stalls until acknowledged, then drains before re-arming.
module pmp_trap_unit #(
    parameter int ADDR_W       = 8,
    parameter int CNT_W        = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] Data_Addr,
    input  logic              Mem_Read,
    input  logic              Mem_Write,
    input  logic              instr_pmp_ok,
    input  logic              data_pmp_ok,
    input  logic              Trap_Ack,
    input  logic              Clear_Count,
    output logic              Trap_Req,
    output logic [3:0]        Trap_Cause,
    output logic [ADDR_W-1:0] Trap_PC,
    output logic [ADDR_W-1:0] Trap_Addr,
    output logic              Stall,
    output logic [CNT_W-1:0]  Fault_Count,
    output logic              Count_Ovf
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [3:0]        cause_q, cause_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic if_f, ld_f, st_f, fault, capture;

    assign if_f    = ~instr_pmp_ok;
    assign ld_f    = Mem_Read & ~data_pmp_ok;
    assign st_f    = Mem_Write & ~data_pmp_ok;
    assign fault   = if_f | ld_f | st_f;
    assign capture = (state_q == IDLE) & fault;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (fault) begin
                    state_d = TRAP;
                    pc_d    = PC;
                    if (if_f) begin
                        cause_d = 4'd1;
                        addr_d  = PC;
                    end else if (st_f) begin
                        cause_d = 4'd7;
                        addr_d  = Data_Addr;
                    end else begin
                        cause_d = 4'd5;
                        addr_d  = Data_Addr;
                    end
                end
            end
            TRAP: begin
                if (Trap_Ack) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d = IDLE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over saturation; a same-cycle capture still counts once.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (Clear_Count) begin
            cnt_d = capture ? CNT_W'(1) : '0;
            ovf_d = 1'b0;
        end else if (capture) begin
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            drain_q <= '0;
            cause_q <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Trap_Req    = (state_q == TRAP);
    assign Stall       = ~Reset & (capture | (state_q != IDLE));
    assign Trap_Cause  = cause_q;
    assign Trap_PC     = pc_q;
    assign Trap_Addr   = addr_q;
    assign Fault_Count = cnt_q;
    assign Count_Ovf   = ovf_q;

endmodule
